carry_save_resolver: RTL

Multi-cycle carry-propagate stage that converts a carry-save pair (sum vector, carry vector) into an ordinary binary result. It is the consumer end of the carry-save adder tree in the arithmetic-logic datapath. It sits after one or more carry-save adders and resolves their redundant output CHUNK bits per cycle. A valid/ready handshake is used on both sides.

---
 rtl/carry_save_resolver.sv | 101 ++++++++++
 1 files changed

// File: rtl/carry_save_resolver.sv
// Resolves a carry-save pair (s, cout) into s + 2*cout, CHUNK bits per cycle.
// Optional ovf output is enabled by defining CSA_RESOLVE_OVF_EN.
module carry_save_resolver #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int JW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a;
    logic [WIDTH:0]   b;      // cout pre-shifted left by one; b[WIDTH] is the top carry bit
    logic             carry;
    logic [JW-1:0]    j;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   sum_c;
    logic [1:0]       hi;
    logic             last;

    always_comb begin
        a_ch  = a[j*CHUNK +: CHUNK];
        b_ch  = b[j*CHUNK +: CHUNK];
        sum_c = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        // A has a zero at bit WIDTH, so only B's top bit meets the final carry.
        hi    = {b[WIDTH] & sum_c[CHUNK], b[WIDTH] ^ sum_c[CHUNK]};
        last  = (j == JW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            a         <= '0;
            b         <= '0;
            carry     <= 1'b0;
            j         <= '0;
`ifdef CSA_RESOLVE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a        <= s;
                        b        <= {cout, 1'b0};
                        carry    <= 1'b0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[j*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
                    carry <= sum_c[CHUNK];
                    if (last) begin
                        result[WIDTH+1:WIDTH] <= hi;
`ifdef CSA_RESOLVE_OVF_EN
                        ovf <= |hi;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef CSA_RESOLVE_OVF_EN
                        ovf       <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
